// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake bundle for the MIPS divider.
// master = control unit side, slave = divider side.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
  logic             is_unsigned;
`endif
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
  modport master (
    output start, dividend, divisor, is_unsigned,
    input  busy, done, div_zero, hi, lo
  );
  modport slave (
    input  start, dividend, divisor, is_unsigned,
    output busy, done, div_zero, hi, lo
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, div_zero, hi, lo
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_zero, hi, lo
  );
`endif
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring signed divider, one quotient bit per cycle.
// Ports: clk, reset (async low), bus (slave: start, dividend, divisor,
// [is_unsigned when SEQ_DIVIDER_UNSIGNED_EN], busy, done, div_zero, hi, lo).
module seq_divider #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        reset,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] hiR;
  logic [WIDTH-1:0] loR;
  logic             signA;
  logic             signB;
  logic             uns;
  logic             zeroPend;
  logic             busyR;
  logic             doneR;
  logic             zeroR;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign bus.busy     = busyR;
  assign bus.done     = doneR;
  assign bus.div_zero = zeroR;
  assign bus.hi       = hiR;
  assign bus.lo       = loR;

  // Extra top bit makes the trial subtract's sign the borrow.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, mag};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      opA      <= '0;
      opB      <= '0;
      mag      <= '0;
      rem      <= '0;
      quo      <= '0;
      hiR      <= '0;
      loR      <= '0;
      signA    <= 1'b0;
      signB    <= 1'b0;
      uns      <= 1'b0;
      zeroPend <= 1'b0;
      busyR    <= 1'b0;
      doneR    <= 1'b0;
      zeroR    <= 1'b0;
    end else begin
      doneR <= 1'b0;
      zeroR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            opA      <= bus.dividend;
            opB      <= bus.divisor;
            signA    <= bus.dividend[WIDTH-1];
            signB    <= bus.divisor[WIDTH-1];
`ifdef SEQ_DIVIDER_UNSIGNED_EN
            uns      <= bus.is_unsigned;
`else
            uns      <= 1'b0;
`endif
            zeroPend <= 1'b0;
            busyR    <= 1'b1;
            state    <= PREP;
          end
        end
        PREP: begin
          if (opB == '0) begin
            // Zero divisor takes the FIX step too, leaving hi/lo alone,
            // so done/div_zero are issued by the same FIX->DONE edge.
            zeroPend <= 1'b1;
            state    <= FIX;
          end else begin
            quo   <= (signA && !uns) ? -opA : opA;
            mag   <= (signB && !uns) ? -opB : opB;
            rem   <= '0;
            cnt   <= CW'(WIDTH);
            state <= ITER;
          end
        end
        ITER: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (!zeroPend) begin
            loR <= ((signA ^ signB) && !uns) ? -quo : quo;
            hiR <= (signA && !uns) ? -rem : rem;
          end
          busyR <= 1'b0;
          doneR <= 1'b1;
          zeroR <= zeroPend;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider
// against an arithmetic reference model.
module tb_seq_divider;
  localparam int W = 32;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
  localparam bit HASU = 1'b1;
`else
  localparam bit HASU = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int nAssert = 0;
  int nFail = 0;
  logic [W-1:0] expHi = '0;
  logic [W-1:0] expLo = '0;

  task automatic check(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // MIPS DIV/DIVU: 64-bit arithmetic, truncate toward zero, wrap to W.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit u);
    longint sa, sb, q, r;
    if (b == '0) return;
    if (u) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    q = sa / sb;
    r = sa % sb;
    expLo = q[W-1:0];
    expHi = r[W-1:0];
  endtask

  task automatic setU(input bit u);
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    bus.is_unsigned = u;
`else
    if (u) $display("note: unsigned request ignored");
`endif
  endtask

  task automatic runDiv(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit u, input string tag);
    int n;
    int lat;
    bit busyOk;
    @(negedge clk);
    bus.dividend = a;
    bus.divisor = b;
    setU(u);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dividend = $urandom;
    bus.divisor = $urandom;
    lat = (b == '0) ? 2 : W + 2;
    n = 0;
    busyOk = 1'b1;
    while (n < 60) begin
      if (bus.busy !== 1'b1) busyOk = 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (bus.done === 1'b1) break;
    end
    model(a, b, u);
    check({tag, ".latency"}, W'(n), W'(lat));
    check({tag, ".busyRun"}, W'(busyOk), W'(1));
    check({tag, ".lo"}, bus.lo, expLo);
    check({tag, ".hi"}, bus.hi, expHi);
    check({tag, ".divZero"}, W'(bus.div_zero), W'(b == '0));
    check({tag, ".busyDone"}, W'(bus.busy), W'(0));
    @(posedge clk);
    #1;
    check({tag, ".donePulse"}, W'(bus.done), W'(0));
    check({tag, ".zeroPulse"}, W'(bus.div_zero), W'(0));
  endtask

  initial begin
    int dones;
    logic [W-1:0] ra, rb;
    bit ru;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    setU(1'b0);
    #12;
    check("rst.busy", W'(bus.busy), W'(0));
    check("rst.done", W'(bus.done), W'(0));
    check("rst.divZero", W'(bus.div_zero), W'(0));
    check("rst.hi", bus.hi, W'(0));
    check("rst.lo", bus.lo, W'(0));
    @(negedge clk);
    reset = 1'b1;

    runDiv(32'd100, 32'd7, 1'b0, "pos");
    check("pos.loConst", bus.lo, 32'd14);
    check("pos.hiConst", bus.hi, 32'd2);
    runDiv(32'hFFFFFF9C, 32'd7, 1'b0, "negA");
    check("negA.loConst", bus.lo, 32'hFFFFFFF2);
    check("negA.hiConst", bus.hi, 32'hFFFFFFFE);
    runDiv(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b0, "negAB");
    check("negAB.loConst", bus.lo, 32'h0000000E);
    check("negAB.hiConst", bus.hi, 32'hFFFFFFFE);
    runDiv(32'h80000000, 32'hFFFFFFFF, 1'b0, "ovf");
    check("ovf.loConst", bus.lo, 32'h80000000);
    check("ovf.hiConst", bus.hi, 32'h0);
    runDiv(32'd100, 32'd7, 1'b0, "pre0");
    runDiv(32'd55, 32'd0, 1'b0, "div0");
    check("div0.loHeld", bus.lo, 32'd14);
    check("div0.hiHeld", bus.hi, 32'd2);

    // Second start mid-run must be ignored.
    @(negedge clk);
    bus.dividend = 32'd1000;
    bus.divisor = 32'd33;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones = 0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dones++;
      if (n == 9) begin
        bus.dividend = 32'd5;
        bus.divisor = 32'd1;
        bus.start = 1'b1;
      end
      if (n == 10) bus.start = 1'b0;
    end
    check("restart.dones", W'(dones), W'(1));
    check("restart.lo", bus.lo, 32'd30);
    check("restart.hi", bus.hi, 32'd10);
    check("restart.idle", W'(bus.busy), W'(0));

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = W'($urandom_range(1, 15));
      if (i % 5 == 0) rb = -W'($urandom_range(1, 9));
      if (i % 7 == 3) ra = -W'($urandom_range(0, 1000));
      ru = HASU ? bit'($urandom_range(0, 1)) : 1'b0;
      runDiv(ra, rb, ru, $sformatf("rnd%0d", i));
    end

`ifdef SEQ_DIVIDER_UNSIGNED_EN
    runDiv(32'hFFFFFFFE, 32'd2, 1'b1, "divu");
    check("divu.loConst", bus.lo, 32'h7FFFFFFF);
    check("divu.hiConst", bus.hi, 32'h0);
`endif

    // Asynchronous reset in the middle of a division.
    runDiv(32'd1000, 32'd33, 1'b0, "preRst");
    @(negedge clk);
    bus.dividend = 32'd12345;
    bus.divisor = 32'd67;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midRst.busy", W'(bus.busy), W'(0));
    check("midRst.done", W'(bus.done), W'(0));
    check("midRst.hi", bus.hi, W'(0));
    check("midRst.lo", bus.lo, W'(0));
    dones = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dones++;
    end
    check("midRst.noDone", W'(dones), W'(0));
    expHi = '0;
    expLo = '0;
    @(negedge clk);
    reset = 1'b1;
    runDiv(32'd9, 32'd3, 1'b0, "postRst");
    check("postRst.loConst", bus.lo, 32'd3);
    check("postRst.hiConst", bus.hi, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end
endmodule
